// File: rtl/cache_line_arbiter_pkg.sv
// Shared definitions for the cache-line arbiter, the caches and the bmem
// deserializer.
//   arb_state_t : arbiter FSM states
//   grant_t     : which cache was granted most recently
//   ADDR_WIDTH  : byte address width of every line port
//   LINE_WIDTH  : line width in bits (4 x 64-bit bmem beats)
package cache_line_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_line_arbiter.sv
// Two-to-one arbiter between the icache and dcache line miss ports and the
// line-wide port of the bmem deserializer.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_dfp_addr/read               icache line read request (level)
//   i_dfp_rdata/resp              line and one-cycle completion to the icache
//   d_dfp_addr/read/write/wdata   dcache read or writeback request (level)
//   d_dfp_rdata/resp              line and one-cycle completion to the dcache
//   dfp_addr/read/write/wdata     latched command to the deserializer
//   dfp_rdata/resp                line and completion from the deserializer
//
// A grant latches the winner's address, command and write data; these stay
// frozen until the deserializer answers. The response is steered back
// combinationally. A one-cycle DONE state follows each transaction so that the
// caches can drop their request levels before the next arbitration.
module cache_line_arbiter #(
    parameter int ADDR_WIDTH = cache_line_arbiter_pkg::ADDR_WIDTH,
    parameter int LINE_WIDTH = cache_line_arbiter_pkg::LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_dfp_addr,
    input  logic                  i_dfp_read,
    output logic [LINE_WIDTH-1:0] i_dfp_rdata,
    output logic                  i_dfp_resp,

    input  logic [ADDR_WIDTH-1:0] d_dfp_addr,
    input  logic                  d_dfp_read,
    input  logic                  d_dfp_write,
    input  logic [LINE_WIDTH-1:0] d_dfp_wdata,
    output logic [LINE_WIDTH-1:0] d_dfp_rdata,
    output logic                  d_dfp_resp,

    output logic [ADDR_WIDTH-1:0] dfp_addr,
    output logic                  dfp_read,
    output logic                  dfp_write,
    output logic [LINE_WIDTH-1:0] dfp_wdata,
    input  logic [LINE_WIDTH-1:0] dfp_rdata,
    input  logic                  dfp_resp
);

    import cache_line_arbiter_pkg::*;

    arb_state_t            state_reg,      state_next;
    grant_t                last_grant_reg, last_grant_next;
    logic [ADDR_WIDTH-1:0] addr_reg,       addr_next;
    logic [LINE_WIDTH-1:0] wdata_reg,      wdata_next;
    logic                  read_reg,       read_next;
    logic                  write_reg,      write_next;

    logic pend_i;
    logic pend_d;
    logic grant_d;

    assign pend_i = i_dfp_read;
    assign pend_d = d_dfp_read | d_dfp_write;

    // D wins when it is alone, or when both pend and I was served last.
    assign grant_d = pend_d & (~pend_i | (last_grant_reg == GRANT_I));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_I;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            read_reg       <= read_next;
            write_reg      <= write_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        read_next       = read_reg;
        write_next      = write_reg;

        unique case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next      = SERVE_D;
                    last_grant_next = GRANT_D;
                    addr_next       = d_dfp_addr;
                    wdata_next      = d_dfp_wdata;
                    // A simultaneous read and write is illegal; the write wins.
                    write_next      = d_dfp_write;
                    read_next       = ~d_dfp_write;
                end else if (pend_i) begin
                    state_next      = SERVE_I;
                    last_grant_next = GRANT_I;
                    addr_next       = i_dfp_addr;
                    wdata_next      = '0;
                    write_next      = 1'b0;
                    read_next       = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                // Commands drop the cycle after the response, i.e. in DONE.
                if (dfp_resp) begin
                    state_next = DONE;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dfp_addr  = addr_reg;
    assign dfp_wdata = wdata_reg;
    assign dfp_read  = read_reg;
    assign dfp_write = write_reg;

    // Responses outside SERVE_* are dropped here.
    assign i_dfp_resp  = (state_reg == SERVE_I) & dfp_resp;
    assign d_dfp_resp  = (state_reg == SERVE_D) & dfp_resp;
    assign i_dfp_rdata = dfp_rdata;
    assign d_dfp_rdata = dfp_rdata;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed testbench for cache_line_arbiter. Inputs change 1 time unit after
// the rising edge and outputs are checked 1 time unit later, well away from
// the next edge.
module tb_cache_line_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_dfp_addr;
    logic          i_dfp_read;
    logic [LW-1:0] i_dfp_rdata;
    logic          i_dfp_resp;
    logic [AW-1:0] d_dfp_addr;
    logic          d_dfp_read;
    logic          d_dfp_write;
    logic [LW-1:0] d_dfp_wdata;
    logic [LW-1:0] d_dfp_rdata;
    logic          d_dfp_resp;
    logic [AW-1:0] dfp_addr;
    logic          dfp_read;
    logic          dfp_write;
    logic [LW-1:0] dfp_wdata;
    logic [LW-1:0] dfp_rdata;
    logic          dfp_resp;

    int pass_count;
    int check_count;
    int illegal_count;

    cache_line_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_dfp_addr  (i_dfp_addr),
        .i_dfp_read  (i_dfp_read),
        .i_dfp_rdata (i_dfp_rdata),
        .i_dfp_resp  (i_dfp_resp),
        .d_dfp_addr  (d_dfp_addr),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write),
        .d_dfp_wdata (d_dfp_wdata),
        .d_dfp_rdata (d_dfp_rdata),
        .d_dfp_resp  (d_dfp_resp),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read and write requested together by the dcache is illegal stimulus.
    always @(posedge clk) begin
        if (!rst && d_dfp_read && d_dfp_write) illegal_count++;
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
            $display("ok   %s = %0h", tag, got);
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".dfp_read"},   dfp_read,   1'b0);
        check({tag, ".dfp_write"},  dfp_write,  1'b0);
        check({tag, ".i_resp"},     i_dfp_resp, 1'b0);
        check({tag, ".d_resp"},     d_dfp_resp, 1'b0);
    endtask

    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_wb;
    logic [LW-1:0] line_5a;
    logic [AW-1:0] exp_addr;

    initial begin
        pass_count    = 0;
        check_count   = 0;
        illegal_count = 0;
        line_a5 = {32{8'hA5}};
        line_wb = {4{64'h0123_4567_89AB_CDEF}};
        line_5a = {32{8'h5A}};

        rst         = 1'b1;
        i_dfp_addr  = '0;
        i_dfp_read  = 1'b0;
        d_dfp_addr  = '0;
        d_dfp_read  = 1'b0;
        d_dfp_write = 1'b0;
        d_dfp_wdata = '0;
        dfp_rdata   = '0;
        dfp_resp    = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        #1;
        check_idle_outputs("reset");
        check("reset.dfp_addr",  dfp_addr,  '0);
        check("reset.dfp_wdata", dfp_wdata, '0);
        rst = 1'b0;

        // ---------------- icache read only ----------------
        step();
        i_dfp_addr = 32'h0000_1000;
        i_dfp_read = 1'b1;
        step();                                 // SERVE_I
        #1;
        check("iread.dfp_read", dfp_read, 1'b1);
        check("iread.dfp_write", dfp_write, 1'b0);
        check("iread.dfp_addr", dfp_addr, 32'h0000_1000);
        step();
        step();
        dfp_resp  = 1'b1;
        dfp_rdata = line_a5;
        #1;
        check("iread.hold_read", dfp_read, 1'b1);
        check("iread.i_resp", i_dfp_resp, 1'b1);
        check("iread.i_rdata", i_dfp_rdata, line_a5);
        check("iread.d_resp", d_dfp_resp, 1'b0);
        step();                                 // DONE
        dfp_resp   = 1'b0;
        i_dfp_read = 1'b0;
        #1;
        check("iread.done_read", dfp_read, 1'b0);
        check("iread.done_i_resp", i_dfp_resp, 1'b0);
        step();                                 // IDLE

        // ---------------- dcache writeback ----------------
        d_dfp_addr  = 32'h0000_2020;
        d_dfp_wdata = line_wb;
        d_dfp_write = 1'b1;
        step();                                 // SERVE_D
        // Requester changes must be ignored while serving.
        d_dfp_addr  = 32'h0000_3FE0;
        d_dfp_wdata = line_5a;
        for (int beat = 0; beat < 4; beat++) begin
            if (beat == 3) dfp_resp = 1'b1;
            #1;
            check($sformatf("wb.beat%0d.write", beat), dfp_write, 1'b1);
            check($sformatf("wb.beat%0d.read", beat), dfp_read, 1'b0);
            check($sformatf("wb.beat%0d.wdata", beat), dfp_wdata, line_wb);
            check($sformatf("wb.beat%0d.addr", beat), dfp_addr, 32'h0000_2020);
            if (beat < 3) step();
        end
        check("wb.d_resp", d_dfp_resp, 1'b1);
        check("wb.i_resp", i_dfp_resp, 1'b0);
        step();                                 // DONE
        dfp_resp    = 1'b0;
        d_dfp_write = 1'b0;
        #1;
        check("wb.done_write", dfp_write, 1'b0);
        step();                                 // IDLE

        // ---------------- simultaneous after reset ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_dfp_addr  = 32'h0000_0040;
        i_dfp_read  = 1'b1;
        d_dfp_addr  = 32'h0000_0080;
        d_dfp_wdata = '0;
        d_dfp_read  = 1'b1;
        step();                                 // SERVE_D
        #1;
        check("sim.first_addr", dfp_addr, 32'h0000_0080);
        check("sim.first_read", dfp_read, 1'b1);
        step();
        dfp_resp  = 1'b1;
        dfp_rdata = line_5a;
        #1;
        check("sim.d_resp", d_dfp_resp, 1'b1);
        check("sim.d_rdata", d_dfp_rdata, line_5a);
        check("sim.i_resp_quiet", i_dfp_resp, 1'b0);
        step();                                 // resp+1: DONE
        dfp_resp   = 1'b0;
        d_dfp_read = 1'b0;
        #1;
        check("sim.gap1_read", dfp_read, 1'b0);
        step();                                 // resp+2: IDLE
        #1;
        check("sim.gap2_read", dfp_read, 1'b0);
        step();                                 // resp+3: SERVE_I
        #1;
        check("sim.second_read", dfp_read, 1'b1);
        check("sim.second_addr", dfp_addr, 32'h0000_0040);
        dfp_resp  = 1'b1;
        dfp_rdata = line_a5;
        #1;
        check("sim.i_resp", i_dfp_resp, 1'b1);
        check("sim.d_resp_quiet", d_dfp_resp, 1'b0);
        step();                                 // DONE
        dfp_resp   = 1'b0;
        i_dfp_read = 1'b0;
        step();                                 // IDLE

        // ---------------- persistent contention ----------------
        // Last grant was I, so the order must be D, I, D, I.
        i_dfp_addr = 32'h0000_0100;
        d_dfp_addr = 32'h0000_0200;
        i_dfp_read = 1'b1;
        d_dfp_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();                             // SERVE_*
            exp_addr = (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
            #1;
            check($sformatf("rr.t%0d.addr", k), dfp_addr, exp_addr);
            dfp_resp = 1'b1;
            #1;
            check($sformatf("rr.t%0d.d_resp", k), d_dfp_resp, (k % 2 == 0));
            check($sformatf("rr.t%0d.i_resp", k), i_dfp_resp, (k % 2 == 1));
            step();                             // DONE
            dfp_resp = 1'b0;
            step();                             // IDLE
        end
        i_dfp_read = 1'b0;
        d_dfp_read = 1'b0;

        // ---------------- stray dfp_resp in IDLE ----------------
        step();
        dfp_resp = 1'b1;
        #1;
        check_idle_outputs("stray_idle");
        step();
        dfp_resp = 1'b0;
        #1;
        check_idle_outputs("stray_idle_after");
        // Still in IDLE: a fresh request is granted on the next edge.
        i_dfp_addr = 32'h0000_0400;
        i_dfp_read = 1'b1;
        step();                                 // SERVE_I
        #1;
        check("stray.grant_read", dfp_read, 1'b1);
        check("stray.grant_addr", dfp_addr, 32'h0000_0400);
        dfp_resp = 1'b1;
        step();                                 // DONE, resp held high: stray
        i_dfp_read = 1'b0;
        #1;
        check_idle_outputs("stray_done");
        step();                                 // IDLE
        dfp_resp = 1'b0;
        #1;
        check_idle_outputs("stray_done_after");

        // ---------------- reset mid SERVE_D ----------------
        d_dfp_addr  = 32'h0000_0300;
        d_dfp_wdata = line_wb;
        d_dfp_write = 1'b1;
        step();                                 // SERVE_D cycle 1
        #1;
        check("rstmid.write", dfp_write, 1'b1);
        step();                                 // SERVE_D cycle 2
        rst = 1'b1;
        step();                                 // reset applied
        rst         = 1'b0;
        d_dfp_write = 1'b0;
        dfp_resp    = 1'b1;
        #1;
        check_idle_outputs("rstmid");
        check("rstmid.dfp_addr", dfp_addr, '0);
        check("rstmid.dfp_wdata", dfp_wdata, '0);
        step();
        dfp_resp   = 1'b0;
        i_dfp_addr = 32'h0000_0500;
        i_dfp_read = 1'b1;
        step();                                 // SERVE_I
        #1;
        check("post_rst.read", dfp_read, 1'b1);
        check("post_rst.addr", dfp_addr, 32'h0000_0500);
        dfp_resp  = 1'b1;
        dfp_rdata = line_a5;
        #1;
        check("post_rst.i_resp", i_dfp_resp, 1'b1);
        check("post_rst.i_rdata", i_dfp_rdata, line_a5);
        step();
        dfp_resp   = 1'b0;
        i_dfp_read = 1'b0;
        #1;
        check("post_rst.done_read", dfp_read, 1'b0);
        step();

        check("illegal_stimulus_count", illegal_count, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/cache_line_arbiter.md
# cache_line_arbiter

Two-to-one cache-line arbiter between the instruction cache and data cache miss ports and the single line-wide memory port of the bmem deserializer. Each cache presents one outstanding 256-bit line request at a time. The arbiter grants one cache, forwards its address, command and write data downstream, and routes the line response back to that cache only. A mandatory one-cycle quiet gap between transactions guarantees that the deserializer's write beat counter and the caches' request lines return low before the next grant.

## Interface
- ADDR_WIDTH, 32, byte address width of all line ports
- LINE_WIDTH, 256, line width in bits (4 x 64-bit bmem beats)
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- i_dfp_addr  in  ADDR_WIDTH  icache line address, 32-byte aligned
- i_dfp_read  in  1  icache line read request, level, held until i_dfp_resp
- i_dfp_rdata  out  LINE_WIDTH  line returned to the icache
- i_dfp_resp  out  1  one-cycle icache completion pulse
- d_dfp_addr  in  ADDR_WIDTH  dcache line address, 32-byte aligned
- d_dfp_read  in  1  dcache line read request, level, held until d_dfp_resp
- d_dfp_write  in  1  dcache writeback request, level, held until d_dfp_resp
- d_dfp_wdata  in  LINE_WIDTH  dcache writeback line
- d_dfp_rdata  out  LINE_WIDTH  line returned to the dcache
- d_dfp_resp  out  1  one-cycle dcache completion pulse
- dfp_addr  out  ADDR_WIDTH  latched address to the deserializer
- dfp_read  out  1  line read command
- dfp_write  out  1  line write command
- dfp_wdata  out  LINE_WIDTH  latched writeback line
- dfp_rdata  in  LINE_WIDTH  line from the deserializer
- dfp_resp  in  1  one-cycle completion from the deserializer

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE. Reset state is IDLE. last_grant resets to I.
- IDLE handles requests as follows:
  - pend_i = i_dfp_read. pend_d = d_dfp_read | d_dfp_write.
  - If only one is pending, grant it.
  - If both are pending, grant the side opposite last_grant (round-robin). After reset, a simultaneous request therefore grants D first.
  - On a grant, register the address, command and wdata into the output latch and update last_grant.
- Command: SERVE_I drives dfp_read. For SERVE_D, d_dfp_write=1 drives dfp_write and d_dfp_read=1 drives dfp_read. If both are 1, write wins and the read is ignored; this is illegal stimulus and the bench flags it.
- Hold during SERVE_*:
  - dfp_addr, dfp_wdata and the command stay constant until dfp_resp.
  - Requester input changes are ignored; only the latched copy is used.
- Completion:
  - In SERVE_X, when dfp_resp=1, x_dfp_resp=1 in the same cycle and x_dfp_rdata=dfp_rdata. The other port's resp stays 0.
  - The next state is DONE.
- DONE: lasts one cycle with all dfp commands low and no grant, then the state returns to IDLE.
- dfp_resp outside SERVE_*: dropped, no cache resp generated.
- i_dfp_rdata and d_dfp_rdata are don't-care when their resp is low. Both are driven from dfp_rdata.

## Timing
- Reset values:
  - dfp_read, dfp_write, i_dfp_resp, d_dfp_resp all 0.
  - dfp_addr and dfp_wdata all zeros.
- Request path:
  - A request sampled in IDLE at edge t puts the block in SERVE_* from t+1.
  - dfp_read/dfp_write are registered outputs. They are high from t+1 through the dfp_resp cycle inclusive and low the cycle after.
- Response path: combinational, dfp_resp to x_dfp_resp with zero added latency.
- Minimum spacing: resp cycle, then DONE, then IDLE (grant sampled), then the next SERVE.
  - Two idle command cycles separate back-to-back transactions.
  - Arbitration overhead is 3 cycles per line beyond deserializer latency.
- Caches must drop the request in the cycle after resp. DONE makes a one-cycle-late drop harmless.
- rst mid-transaction:
  - The next cycle is IDLE with all outputs at reset values and no resp emitted.
  - The deserializer is reset on the same rst.

## Structure
- A shared package holds:
  - arb_state_t enum (IDLE, SERVE_I, SERVE_D, DONE)
  - grant_t enum (GRANT_I, GRANT_D)
  - LINE_WIDTH and ADDR_WIDTH constants, reused by the caches and the deserializer
- Single module with no sub-modules:
  - the FSM
  - the output latch (addr, wdata, cmd)
  - the last_grant bit
  - combinational resp/rdata steering

## Test plan
- I read only: i_dfp_read=1, addr 0x0000_1000. Then:
  - dfp_read=1 and dfp_addr=0x0000_1000 one cycle later.
  - Deserializer returns line 0xA5..A5, so i_dfp_resp pulses 1 cycle with that data and d_dfp_resp stays 0.
- D writeback: d_dfp_write=1, addr 0x0000_2020, wdata 0x0123..CDEF. Then:
  - dfp_write=1 held, with dfp_wdata unchanged across all 4 beats.
  - d_dfp_resp is high the same cycle as dfp_resp.
  - dfp_write is low the next cycle.
- Simultaneous I read at 0x40 and D read at 0x80 after reset:
  - D is served first (dfp_addr=0x80).
  - I is granted exactly 3 cycles after D's resp (dfp_addr=0x40).
- Persistent contention, both held through 4 transactions: grants alternate D, I, D, I.
- Stray dfp_resp while IDLE or DONE: no cache resp and no state change.
- rst asserted 2 cycles into SERVE_D:
  - All outputs read 0 the next cycle.
  - A new I request afterward is served normally.
